// File: rtl/ex_resolve_stage.sv
// ex_resolve_stage
// Execute-resolve stage that sits directly after the ALU/shifter. It takes one
// executed instruction per cycle and does the following:
//   - resolves the branch or jump outcome,
//   - forms the SLT/SLTU and link values,
//   - selects the writeback data.
// The resolved entry is registered and offered to writeback over valid/ready.
// A main output register plus one skid register keep the upstream side fully
// pipelined, and in_ready comes straight from a flop.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. While valid is high and ready is low, the producer holds its
// payload stable. Neither side's valid may depend on the other side's ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   fu_out, c_out, z         FU result, carry (1 = no borrow), zero flag
//   op1_msb, op2_msb         sign bits of the FU operands
//   res_kind, br_cond        result kind (0..7), branch funct3
//   pc_plus4, br_target      link value, jump/branch target
//   rd_addr, rd_we           destination register, decode write-enable
//   out_valid / out_ready    downstream handshake
//   wb_data, wb_rd, wb_we    writeback payload
//   redirect, redirect_pc    taken branch/jump and its target (bit 0 cleared)
//   dbg_state                current occupancy state (0 EMPTY, 1 ONE, 2 FULL)
module ex_resolve_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] fu_out,
  input  logic            c_out,
  input  logic            z,
  input  logic            op1_msb,
  input  logic            op2_msb,
  input  logic [2:0]      res_kind,
  input  logic [2:0]      br_cond,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] br_target,
  input  logic [4:0]      rd_addr,
  input  logic            rd_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      dbg_state
);

  // One resolved instruction (71 bits when XLEN = 32).
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
    logic            redir;
    logic [XLEN-1:0] rpc;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  entry_t r_out;
  entry_t r_skid;
  entry_t w_entry;
  logic   r_in_ready;

  logic w_eq;
  logic w_ltu;
  logic w_lt;
  logic w_cond;
  logic w_in_fire;
  logic w_out_fire;
  logic w_load_out;
  logic w_out_from_skid;
  logic w_load_skid;

  // ---------------- Resolve ----------------
  // For a subtraction the carry is 1 when there is no borrow, so the unsigned
  // less-than result is the inverted carry. When the operand signs differ,
  // the signed compare is decided by op1's sign alone.
  assign w_eq  = z;
  assign w_ltu = ~c_out;
  assign w_lt  = (op1_msb != op2_msb) ? op1_msb : w_ltu;

  always_comb begin
    w_cond = 1'b0;
    case (br_cond)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = ~w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = ~w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = ~w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_entry       = '0;
    w_entry.rd    = rd_addr;
    case (res_kind)
      3'd0: w_entry.data = fu_out;
      3'd1: begin
        w_entry.data  = pc_plus4;
        w_entry.redir = 1'b1;
      end
      3'd2: w_entry.data = {{(XLEN-1){1'b0}}, w_lt};
      3'd3: w_entry.data = {{(XLEN-1){1'b0}}, w_ltu};
      3'd4: w_entry.redir = w_cond;
      default: w_entry.redir = 1'b0;
    endcase
    // Writes to x0 are suppressed here, so the register file never needs to
    // special-case them.
    w_entry.we  = rd_we & (res_kind <= 3'd3) & (rd_addr != 5'd0);
    w_entry.rpc = w_entry.redir ? {br_target[XLEN-1:1], 1'b0} : '0;
  end

  // ---------------- Occupancy control ----------------
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = (r_state != S_EMPTY) & out_ready;

  always_comb begin
    w_next          = r_state;
    w_load_out      = 1'b0;
    w_out_from_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_load_out = 1'b1;
          w_next     = S_ONE;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_out = 1'b1;
        end else if (w_in_fire) begin
          w_load_skid = 1'b1;
          w_next      = S_FULL;
        end else if (w_out_fire) begin
          w_next = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only the drain path can move.
        if (w_out_fire) begin
          w_out_from_skid = 1'b1;
          w_next          = S_ONE;
        end
      end
      default: w_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_out      <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      // Computed from the next state so in_ready is a flop output and has
      // no combinational path from out_ready.
      r_in_ready <= (w_next != S_FULL);
      if (w_load_out) begin
        r_out <= w_entry;
      end else if (w_out_from_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_entry;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != S_EMPTY);
  assign wb_data     = r_out.data;
  assign wb_rd       = r_out.rd;
  assign wb_we       = r_out.we;
  assign redirect    = r_out.redir;
  assign redirect_pc = r_out.rpc;
  assign dbg_state   = r_state;

endmodule

// File: doc/ex_resolve_stage.md
# ex_resolve_stage

Execute-resolve stage directly downstream of the functional unit (ALU + shifter). Each cycle it accepts one executed instruction: FU result, carry, zero flag, operand sign bits and decode side-band. It resolves branch/jump outcome, forms SLT/SLTU and link values, and selects the writeback data. Results are registered and presented to the writeback stage over a valid/ready handshake. A 2-entry skid buffer keeps the FU side fully pipelined under back-pressure.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept; equals NOT skid_full.
- fu_out  input  32  FU result; for branches/SLT this is in1 - in2.
- c_out  input  1  FU carry out; for subtraction 1 = no borrow (in1 >= in2 unsigned).
- z  input  1  FU zero flag (fu_out == 0).
- op1_msb, op2_msb  input  1 each  bit 31 of the FU operands.
- res_kind  input  3  0 FU result, 1 link (JAL/JALR), 2 SLT, 3 SLTU, 4 branch, 5-7 reserved.
- br_cond  input  3  funct3 of branch: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 never taken.
- pc_plus4  input  32  link value.
- br_target  input  32  jump/branch target.
- rd_addr  input  5  destination register.
- rd_we  input  1  decode write-enable.
- out_valid  output  1  output entry valid.
- out_ready  input  1  writeback accepts.
- wb_data  output  32  writeback data.
- wb_rd  output  5  destination register.
- wb_we  output  1  effective write-enable.
- redirect  output  1  taken branch or jump; qualified by out_valid.
- redirect_pc  output  32  redirect target, bit 0 forced to 0.

## Operation
- Comparison terms:
  - eq = z
  - ltu = NOT c_out
  - lt = (op1_msb != op2_msb) ? op1_msb : ltu
- Kind 0: wb_data = fu_out; redirect = 0.
- Kind 1: wb_data = pc_plus4; redirect = 1.
- Kind 2: wb_data = {31'b0, lt}. Kind 3: wb_data = {31'b0, ltu}. Redirect = 0 for both.
- Kind 4: wb_we = 0; wb_data = 0.
  - redirect = cond_true(br_cond): BEQ eq, BNE !eq, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu, 010/011 false.
- Kinds 5-7: wb_we = 0, redirect = 0, wb_data = 0. Entry still flows so the upstream never stalls.
- wb_we = rd_we AND kind in {0,1,2,3} AND rd_addr != 0.
- redirect_pc = {br_target[31:1], 1'b0} whenever redirect = 1; otherwise 0.
- All fields are computed combinationally at input and stored as one packed entry (71 bits).
- Storage:
  - Main output register (OUT) plus one skid register (SKID).
  - State encoding: EMPTY (OUT invalid), ONE (OUT valid, SKID empty), FULL (both valid).
- Transitions (in_fire = in_valid & in_ready; out_fire = out_valid & out_ready):
  - EMPTY: in_fire → load OUT, go to ONE.
  - ONE, in_fire & out_fire → OUT reloaded, stay in ONE.
  - ONE, in_fire & !out_fire → load SKID, go to FULL.
  - ONE, !in_fire & out_fire → go to EMPTY.
  - FULL: in_ready = 0. out_fire → OUT ← SKID, go to ONE.
- Ordering is strictly FIFO; no entry is dropped or duplicated.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on outputs after edge N when the stage was EMPTY or drained at N.
- Throughput is 1 entry/cycle while out_ready is held high.
- in_ready is a pure register output: no combinational path from out_ready to in_ready.
- Reset (rst high at an edge) gives:
  - state EMPTY, out_valid = 0, in_ready = 1;
  - wb_data = 0, wb_rd = 0, wb_we = 0, redirect = 0, redirect_pc = 0.
- Reset mid-operation discards both entries regardless of out_ready. Inputs during a reset cycle are ignored.
- Outputs hold stable while out_valid = 1 and out_ready = 0.
- in_valid with in_ready = 0 causes no state change. The upstream holds its entry.

## Test plan
- Basic pass-through: kind 0, fu_out = 0x0000_1234, rd 5, rd_we = 1, out_ready = 1 → next cycle out_valid = 1, wb_data = 0x1234, wb_rd = 5, wb_we = 1, redirect = 0.
- Branches (kind 4):
  - BLT with op1_msb = 1, op2_msb = 0, c_out = 1, z = 0 → redirect = 1, wb_we = 0.
  - BGEU with c_out = 1 → redirect = 1.
  - BEQ with z = 0 → redirect = 0.
  - br_target = 0x0000_0101 → redirect_pc = 0x0000_0100.
- SLT/SLTU and x0:
  - SLTU with c_out = 0 → wb_data = 1.
  - SLT with op1_msb = 0, op2_msb = 1 → wb_data = 0.
  - kind 0 with rd = 0, rd_we = 1 → wb_we = 0.
- Back-pressure: stream entries A, B, C with out_ready = 0.
  - Expect in_ready = 1 then 1 then 0; C held upstream.
  - Raise out_ready → outputs A, B, C in order, no gaps once ready stays high.
- Jump link: kind 1, pc_plus4 = 0x0000_0044, br_target = 0x0000_2000, rd 1 → wb_data = 0x44, wb_we = 1, redirect = 1, redirect_pc = 0x2000.
- Reset mid-operation: FULL with out_ready = 0, assert rst one cycle → out_valid = 0, in_ready = 1, all outputs 0; the next accepted entry appears alone.
